key_debounce: RTL and testbench
===============================

# key_debounce

Front-end conditioner for one raw push-button pin: synchronizes the asynchronous key level into the Clock domain, rejects contact bounce with a consecutive-sample qualification counter, and presents a clean active-high level `pressed`. It sits directly upstream of the one-pulse-per-press `button` stage, whose `pressed` input it drives. A saturating count of rejected bounces is exported for debug LEDs/HEX.

## Interface
- `STABLE_CYCLES`, default 50000: consecutive synchronized samples at the new level required to accept a change; legal range 2..2^20.
- `ACTIVE_LOW`, default 1: 1 = raw pin reads 0 when pressed (DE1 KEY); 0 = raw pin reads 1 when pressed.
- `Clock`  in  1  sole clock; all flops rising-edge.
- `Reset`  in  1  one clock; reset is asynchronous and active-low.
- `key_raw`  in  1  asynchronous pin level, polarity per `ACTIVE_LOW`.
- `pressed`  out  1  debounced level, 1 = held; registered (Moore).
- `glitch_count`  out  8  number of aborted qualifications, saturates at 255.

## Operation
- Input normalization: `k = ACTIVE_LOW ? ~key_raw : key_raw`, then 2-flop synchronizer -> `s`. Synchronizer flops reset to 0 (released).
- Counter `cnt`, width $clog2(STABLE_CYCLES); never exceeds STABLE_CYCLES-1.
- FSM states (shared enum): IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT.
  - IDLE: `s`=1 -> PRESS_WAIT, `cnt`<=1; else stay.
  - PRESS_WAIT: `s`=0 -> IDLE, `glitch_count`++; `s`=1 and `cnt`==STABLE_CYCLES-1 -> DOWN; else `cnt`++.
  - DOWN: `s`=0 -> RELEASE_WAIT, `cnt`<=1; else stay.
  - RELEASE_WAIT: `s`=1 -> DOWN, `glitch_count`++; `s`=0 and `cnt`==STABLE_CYCLES-1 -> IDLE; else `cnt`++.
- `pressed` = 1 in DOWN and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT (state-decoded from a register, glitch-free).
- `glitch_count` saturates: at 255 further aborts leave it at 255; cleared only by reset.
- Reset (`Reset`=0) at any time, including mid-qualification: state IDLE, `cnt`=0, sync flops 0, `pressed`=0, `glitch_count`=0, all immediately (asynchronous). On deassertion a key already held re-qualifies from scratch; no pulse is lost or invented beyond that.

## Timing
- Edge E0 = first rising edge at which sync stage 1 captures the new normalized level.
- Press: if `k` stays 1, `pressed` rises after edge E0+STABLE_CYCLES+1 (2-cycle sync + STABLE_CYCLES qualification samples, first sample taken in IDLE). STABLE_CYCLES=4 -> high after E0+5.
- Release: symmetric; `pressed` falls after edge E0+STABLE_CYCLES+1.
- Any single opposite sample during a WAIT state aborts; qualification restarts from the next opposite-level sample (counter restarts at 1).
- Pulses on `k` shorter than 1 clock may be missed entirely; not an error, no count.
- No combinational path from `key_raw` to any output.

## Structure
- Package `button_pkg`: `typedef enum logic [1:0] {IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT} debounce_state_t;` and constant `GLITCH_MAX = 8'd255`. The downstream `button` FSM state encodings move into the same package.
- One sub-module, `sync2`: 2-flop synchronizer, parameterized reset value, async active-low reset.
- Top of `key_debounce`: sync2 instance, counter, FSM, saturating glitch counter. Target 150-250 lines RTL.

## Test plan
(Bench uses STABLE_CYCLES=4, ACTIVE_LOW=1, 100-unit clock.)
- Reset then idle: `Reset`=0 for 2 cycles, `key_raw`=1 -> `pressed`=0, `glitch_count`=0 throughout, state IDLE.
- Clean press/release: `key_raw` 1->0 before edge E0, held 10 cycles, then 0->1 -> `pressed` high after E0+5, low 5 edges after release capture; `glitch_count`=0.
- Bounce on press: `key_raw` sequence 0,1,0,1,0 (one cycle each) then held 0 -> `pressed` rises only 5 edges after final stable 0 captured; `glitch_count`=2.
- Bounce on release: while DOWN, single-cycle `key_raw`=1 glitch -> `pressed` stays 1, `glitch_count` +1.
- Saturation: 300 single-cycle glitches in IDLE -> `glitch_count`=255, `pressed`=0.
- Reset mid-qualification and while held: assert `Reset` in PRESS_WAIT and in DOWN -> `pressed`=0 immediately (before next edge); release reset with key held -> `pressed` high again 6 edges after deassertion (2 sync + 4 samples).

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encodings and constants for the key/button front end
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    DOWN,
    RELEASE_WAIT
  } debounce_state_t;

  // Encodings of the downstream one-pulse-per-press stage live here too.
  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PULSE,
    BTN_WAIT_RELEASE
  } button_state_t;

  localparam logic [7:0] GLITCH_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == GLITCH_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset level
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic stage1_q;
  logic stage2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage1_q <= RESET_VAL;
      stage2_q <= RESET_VAL;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronize, debounce and count bounces on one push-button pin
module key_debounce
  import button_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key_raw,
  output logic       pressed,
  output logic [7:0] glitch_count
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic            key_norm;
  logic            s;
  debounce_state_t state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            pressed_q;
  logic [7:0]      glitch_q;
  logic [7:0]      glitch_d;

  assign key_norm = ACTIVE_LOW ? ~key_raw : key_raw;

  sync2 #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk_i   (Clock),
    .rst_n_i (Reset),
    .d_i     (key_norm),
    .q_o     (s)
  );

  assign cnt_d    = cnt_q + CNT_ONE;
  assign glitch_d = sat_inc8(glitch_q);

  // pressed_q is updated on the same edge as the state so the output is a plain flop.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      glitch_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_q  <= IDLE;
            glitch_q <= glitch_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= DOWN;
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DOWN: begin
          if (!s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_q  <= DOWN;
            glitch_q <= glitch_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign pressed      = pressed_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with STABLE_CYCLES=4, ACTIVE_LOW=1
module tb_key_debounce;
  import button_pkg::*;

  typedef struct {
    int         cyc;
    logic       p;
    logic [7:0] g;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_raw;
  logic       pressed;
  logic [7:0] glitch_count;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [8:0] prev_out = 9'd0;

  key_debounce #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .key_raw      (key_raw),
    .pressed      (pressed),
    .glitch_count (glitch_count)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #10;
  endtask

  task automatic expect_at(input int c, input logic p, input logic [7:0] g);
    exp_t e;
    e.cyc = c;
    e.p   = p;
    e.g   = g;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if ({pressed, glitch_count} !== prev_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc %0d got pressed=%b glitch=%0d, required no change",
                 cyc, pressed, glitch_count);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.p !== pressed || e.g !== glitch_count) begin
          errors++;
          $display("FAIL output_event: got cyc %0d pressed=%b glitch=%0d, required cyc %0d pressed=%b glitch=%0d",
                   cyc, pressed, glitch_count, e.cyc, e.p, e.g);
        end
      end
      prev_out = {pressed, glitch_count};
    end
  end

  initial begin
    rst_n   = 1'b0;
    key_raw = 1'b1;
    step(2);
    check("reset_pressed", {31'd0, pressed}, 32'd0);
    check("reset_glitch", {24'd0, glitch_count}, 32'd0);
    check("reset_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    rst_n = 1'b1;
    step(4);
    check("idle_pressed", {31'd0, pressed}, 32'd0);
    check("idle_state", {30'd0, dut.state_q}, {30'd0, IDLE});

    // Clean press held 10 cycles, then clean release.
    expect_at(cyc + 6, 1'b1, 8'd0);
    key_raw = 1'b0;
    step(10);
    expect_at(cyc + 6, 1'b0, 8'd0);
    key_raw = 1'b1;
    step(10);

    // Press bounce 0,1,0,1 then held low.
    expect_at(cyc + 4, 1'b0, 8'd1);
    expect_at(cyc + 6, 1'b0, 8'd2);
    expect_at(cyc + 10, 1'b1, 8'd2);
    key_raw = 1'b0; step(1);
    key_raw = 1'b1; step(1);
    key_raw = 1'b0; step(1);
    key_raw = 1'b1; step(1);
    key_raw = 1'b0; step(10);
    check("bounce_press_state", {30'd0, dut.state_q}, {30'd0, DOWN});

    // Single-cycle release glitch while held.
    expect_at(cyc + 4, 1'b1, 8'd3);
    key_raw = 1'b1; step(1);
    key_raw = 1'b0; step(8);
    check("release_glitch_pressed", {31'd0, pressed}, 32'd1);

    expect_at(cyc + 6, 1'b0, 8'd3);
    key_raw = 1'b1;
    step(10);

    // 300 single-cycle glitches from IDLE; count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      if (i < 252) expect_at(cyc + 4, 1'b0, 8'(4 + i));
      key_raw = 1'b0; step(1);
      key_raw = 1'b1; step(1);
    end
    step(6);
    check("sat_glitch", {24'd0, glitch_count}, 32'd255);
    check("sat_pressed", {31'd0, pressed}, 32'd0);

    // Reset during PRESS_WAIT.
    key_raw = 1'b0;
    step(4);
    check("pw_state", {30'd0, dut.state_q}, {30'd0, PRESS_WAIT});
    expect_at(cyc, 1'b0, 8'd0);
    rst_n = 1'b0;
    #1;
    check("pw_reset_glitch", {24'd0, glitch_count}, 32'd0);
    check("pw_reset_pressed", {31'd0, pressed}, 32'd0);
    step(2);
    expect_at(cyc + 6, 1'b1, 8'd0);
    rst_n = 1'b1;
    step(8);

    // Reset while DOWN with key still held.
    expect_at(cyc, 1'b0, 8'd0);
    rst_n = 1'b0;
    #1;
    check("down_reset_pressed", {31'd0, pressed}, 32'd0);
    check("down_reset_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    step(2);
    expect_at(cyc + 6, 1'b1, 8'd0);
    rst_n = 1'b1;
    step(8);

    expect_at(cyc + 6, 1'b0, 8'd0);
    key_raw = 1'b1;
    step(10);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
